// File: rtl/tt_pkg.sv
// Shared definitions for the truth-table sweep evaluator: FSM encoding and table sizing.
package tt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_FIN   = 2'd2
  } tt_state_t;

  function automatic int tt_width(input int n_in);
    return 1 << n_in;
  endfunction

endpackage

// File: rtl/tt_sweep_eval_if.sv
// Control/result bundle of the sweep evaluator; master drives table and commands, slave reports samples.
interface tt_sweep_eval_if #(
  parameter int N_IN = 4
);
  import tt_pkg::*;
  localparam int TW = tt_width(N_IN);

  logic            tt_load;
  logic [TW-1:0]   tt_in;
  logic            start;
  logic            abort;
  logic [N_IN-1:0] vec;
  logic            f;
  logic            valid;
  logic            busy;
  logic            done;
  logic [N_IN:0]   ones_cnt;
  logic [N_IN-1:0] dep_mask;
  logic            load_err;

  modport master (
    output tt_load, tt_in, start, abort,
    input  vec, f, valid, busy, done, ones_cnt, dep_mask, load_err
  );

  modport slave (
    input  tt_load, tt_in, start, abort,
    output vec, f, valid, busy, done, ones_cnt, dep_mask, load_err
  );

endinterface

// File: rtl/tt_dep_check.sv
// Combinational per-input dependence test at one vector; zero latency, no flow control.
// hit[i] is set when flipping input bit i changes the table output.
module tt_dep_check
  import tt_pkg::*;
#(
  parameter int N_IN = 4
) (
  input  logic [tt_width(N_IN)-1:0] tbl,
  input  logic [N_IN-1:0]           vec,
  output logic [N_IN-1:0]           hit
);

  always_comb begin
    hit = '0;
    for (int i = 0; i < N_IN; i++) begin
      hit[i] = tbl[vec] ^ tbl[vec ^ (N_IN'(1) << i)];
    end
  end

endmodule

// File: rtl/tt_sweep_eval.sv
// Sweeps all 2^N_IN vectors of a loaded truth table, STEP_CYC cycles per vector; first sample one cycle after start.
// No backpressure: commands outside IDLE are dropped (tt_load flags load_err), abort ends a sweep early.
module tt_sweep_eval
  import tt_pkg::*;
#(
  parameter int N_IN     = 4,
  parameter int STEP_CYC = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  tt_sweep_eval_if.slave  bus
);

  localparam int              TW        = tt_width(N_IN);
  localparam int              CW        = N_IN + 1;
  localparam logic [7:0]      HOLD_LAST = 8'(STEP_CYC - 1);
  localparam logic [N_IN-1:0] VEC_LAST  = '1;

  tt_state_t       state, state_nxt;
  logic [TW-1:0]   tbl;
  logic [N_IN-1:0] vec;
  logic [7:0]      hold;
  logic [CW-1:0]   ones_cnt;
  logic [N_IN-1:0] dep_mask;
  logic            load_err;
  logic [N_IN-1:0] hit;
  logic            valid;
  logic            f;
  logic            hold_end;

  assign f        = tbl[vec];
  assign valid    = (state == ST_SWEEP) && (hold == 8'd0);
  assign hold_end = (hold == HOLD_LAST);

  tt_dep_check #(.N_IN(N_IN)) u_dep (
    .tbl (tbl),
    .vec (vec),
    .hit (hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (bus.start) state_nxt = ST_SWEEP;
      ST_SWEEP: begin
        if (bus.abort)                         state_nxt = ST_IDLE;
        else if (hold_end && vec == VEC_LAST)  state_nxt = ST_FIN;
      end
      ST_FIN:   state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tbl      <= '0;
      vec      <= '0;
      hold     <= '0;
      ones_cnt <= '0;
      dep_mask <= '0;
      load_err <= 1'b0;
    end else begin
      load_err <= bus.tt_load && (state != ST_IDLE);
      case (state)
        ST_IDLE: begin
          if (bus.tt_load) tbl <= bus.tt_in;
          if (bus.start) begin
            vec      <= '0;
            hold     <= '0;
            ones_cnt <= '0;
            dep_mask <= '0;
          end
        end
        ST_SWEEP: begin
          if (valid) begin
            ones_cnt <= ones_cnt + CW'(f);
            dep_mask <= dep_mask | hit;
          end
          // the last vector is left on vec so the final sample stays visible
          if (!bus.abort) begin
            if (hold_end) begin
              hold <= '0;
              if (vec != VEC_LAST) vec <= vec + N_IN'(1);
            end else begin
              hold <= hold + 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.vec      = vec;
  assign bus.f        = f;
  assign bus.valid    = valid;
  assign bus.busy     = (state == ST_SWEEP);
  assign bus.done     = (state == ST_FIN);
  assign bus.ones_cnt = ones_cnt;
  assign bus.dep_mask = dep_mask;
  assign bus.load_err = load_err;

endmodule

// File: tb/tb_tt_sweep_eval.sv
// Directed bench for tt_sweep_eval: a 4-input/1-cycle and a 3-input/3-cycle instance against hand-computed results.
module tb_tt_sweep_eval;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  tt_sweep_eval_if #(.N_IN(4)) b4 ();
  tt_sweep_eval_if #(.N_IN(3)) b3 ();

  tt_sweep_eval #(.N_IN(4), .STEP_CYC(1)) u4 (.clk(clk), .rst_n(rst_n), .bus(b4.slave));
  tt_sweep_eval #(.N_IN(3), .STEP_CYC(3)) u3 (.clk(clk), .rst_n(rst_n), .bus(b3.slave));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Returns positioned in the first sweep cycle (start edge + 1).
  task automatic start4(input logic [15:0] tt, input logic with_abort, input logic same_cycle);
    b4.tt_load = 1'b1;
    b4.tt_in   = tt;
    if (!same_cycle) begin
      tick;
      b4.tt_load = 1'b0;
    end
    b4.start = 1'b1;
    b4.abort = with_abort;
    tick;
    b4.tt_load = 1'b0;
    b4.start   = 1'b0;
    b4.abort   = 1'b0;
  endtask

  // cyc counts cycles after the start edge; returns positioned in the done cycle.
  task automatic wait_done4(output int cyc, output bit seen);
    cyc  = 1;
    seen = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      if (b4.done) seen = 1'b1;
      else begin
        tick;
        cyc++;
      end
    end
  endtask

  logic [15:0] tt4;
  logic [7:0]  tt3;
  int          cyc, cnt, le;
  bit          seen;

  initial begin
    b4.tt_load = 1'b0; b4.tt_in = '0; b4.start = 1'b0; b4.abort = 1'b0;
    b3.tt_load = 1'b0; b3.tt_in = '0; b3.start = 1'b0; b3.abort = 1'b0;
    rst_n = 1'b0;
    #12;
    check("rst_vec",  b4.vec, 0);
    check("rst_f",    b4.f, 0);
    check("rst_vld",  b4.valid, 0);
    check("rst_busy", b4.busy, 0);
    check("rst_done", b4.done, 0);
    check("rst_ones", b4.ones_cnt, 0);
    check("rst_dep",  b4.dep_mask, 0);
    check("rst_lerr", b4.load_err, 0);
    check("rst3_busy", b3.busy, 0);
    check("rst3_ones", b3.ones_cnt, 0);
    tick;
    rst_n = 1'b1;
    tick;

    // f = ab | b~c, input d unused
    tt4 = 16'hF030;
    start4(tt4, 1'b0, 1'b0);
    check("t1_lerr", b4.load_err, 0);
    for (int k = 0; k < 16; k++) begin
      check("t1_vld",  b4.valid, 1);
      check("t1_busy", b4.busy, 1);
      check("t1_vec",  b4.vec, k);
      check("t1_f",    b4.f, tt4[k]);
      tick;
    end
    check("t1_done", b4.done, 1);
    check("t1_busy_fin", b4.busy, 0);
    check("t1_vld_fin",  b4.valid, 0);
    check("t1_vec_fin",  b4.vec, 15);
    check("t1_ones", b4.ones_cnt, 6);
    check("t1_dep",  b4.dep_mask, 4'b1110);
    tick;
    check("t1_done_drop", b4.done, 0);
    check("t1_ones_hold", b4.ones_cnt, 6);
    check("t1_dep_hold",  b4.dep_mask, 4'b1110);

    // 3-input XOR, each vector held 3 cycles
    tt3 = 8'b1001_0110;
    b3.tt_load = 1'b1; b3.tt_in = tt3;
    tick;
    b3.tt_load = 1'b0; b3.start = 1'b1;
    tick;
    b3.start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      for (int h = 0; h < 3; h++) begin
        check("t2_vld", b3.valid, (h == 0) ? 1 : 0);
        check("t2_vec", b3.vec, k);
        check("t2_f",   b3.f, tt3[k]);
        tick;
      end
    end
    check("t2_done", b3.done, 1);
    check("t2_ones", b3.ones_cnt, 4);
    check("t2_dep",  b3.dep_mask, 3'b111);

    // constant tables; the all-ones case loads and starts in one cycle
    tick;
    start4(16'h0000, 1'b0, 1'b0);
    wait_done4(cyc, seen);
    check("t3z_seen", seen, 1);
    check("t3z_ones", b4.ones_cnt, 0);
    check("t3z_dep",  b4.dep_mask, 0);
    tick;
    start4(16'hFFFF, 1'b0, 1'b1);
    check("t3f_f0", b4.f, 1);
    wait_done4(cyc, seen);
    check("t3f_seen", seen, 1);
    check("t3f_cyc",  cyc, 17);
    check("t3f_ones", b4.ones_cnt, 5'b10000);
    check("t3f_dep",  b4.dep_mask, 0);

    // abort on vec 6
    tick;
    start4(16'hF030, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) tick;
    check("t4_vec6", b4.vec, 6);
    b4.abort = 1'b1;
    tick;
    b4.abort = 1'b0;
    check("t4_busy", b4.busy, 0);
    check("t4_vld",  b4.valid, 0);
    check("t4_done", b4.done, 0);
    check("t4_ones", b4.ones_cnt, 2);
    check("t4_dep",  b4.dep_mask, 4'b1110);
    cnt = 0;
    for (int i = 0; i < 25; i++) begin
      if (b4.done) cnt++;
      tick;
    end
    check("t4_nodone",   cnt, 0);
    check("t4_ones_ret", b4.ones_cnt, 2);

    // tt_load and start during a sweep are ignored
    start4(16'hF030, 1'b0, 1'b0);
    cyc = 1; le = 0; seen = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      b4.tt_load = (cyc == 3);
      b4.tt_in   = 16'hFFFF;
      b4.start   = (cyc == 6);
      if (b4.load_err) le++;
      if (b4.done) seen = 1'b1;
      else begin
        tick;
        cyc++;
      end
    end
    b4.tt_load = 1'b0; b4.start = 1'b0;
    check("t5_seen", seen, 1);
    check("t5_cyc",  cyc, 17);
    check("t5_lerr", le, 1);
    check("t5_ones", b4.ones_cnt, 6);
    check("t5_dep",  b4.dep_mask, 4'b1110);

    // start and abort together in IDLE
    tick;
    start4(16'hF030, 1'b1, 1'b0);
    check("t6_busy", b4.busy, 1);
    check("t6_vld",  b4.valid, 1);
    wait_done4(cyc, seen);
    check("t6_seen", seen, 1);
    check("t6_cyc",  cyc, 17);
    check("t6_ones", b4.ones_cnt, 6);

    // reset mid-sweep at vec 9
    tick;
    start4(16'hF030, 1'b0, 1'b0);
    for (int k = 0; k < 9; k++) tick;
    check("t7_vec9", b4.vec, 9);
    check("t7_ones_pre", b4.ones_cnt, 2);
    #2 rst_n = 1'b0;
    #1;
    check("t7_vec",  b4.vec, 0);
    check("t7_f",    b4.f, 0);
    check("t7_busy", b4.busy, 0);
    check("t7_vld",  b4.valid, 0);
    check("t7_ones", b4.ones_cnt, 0);
    check("t7_dep",  b4.dep_mask, 0);
    tick;
    check("t7_done", b4.done, 0);
    rst_n = 1'b1;
    tick;
    b4.start = 1'b1;
    tick;
    b4.start = 1'b0;
    check("t7_busy2", b4.busy, 1);
    wait_done4(cyc, seen);
    check("t7_seen", seen, 1);
    check("t7_ones2", b4.ones_cnt, 0);
    check("t7_dep2",  b4.dep_mask, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
